// File: rtl/busca_instrucao_pkg.sv
// Shared encodings for the fetch stage and the control unit:
// FSM states, FonteCP codes and the PC write enable rule.
package busca_instrucao_pkg;

   typedef enum logic [1:0] {
      REINICIO = 2'b00,
      BUSCA    = 2'b01,
      PRONTO   = 2'b10
   } estado_t;

   localparam logic [1:0] FCP_SEQ = 2'b00;
   localparam logic [1:0] FCP_ULA = 2'b01;
   localparam logic [1:0] FCP_JMP = 2'b10;

   // Unconditional write, or conditional write taken on zero
   function automatic logic escreve_pc(
      input logic esc,
      input logic cond,
      input logic zero
   );
      return esc & (~cond | zero);
   endfunction

endpackage

// File: rtl/busca_instrucao_calc_prox_pc.sv
// Next-PC selection: sequential, ALU target or in-page jump.
// The reserved code keeps the PC so the same word is re-fetched.
module busca_instrucao_calc_prox_pc
   import busca_instrucao_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] ula_res,
   input  logic [11:0]       imm12,
   input  logic [1:0]        fonte_cp,
   output logic [ADDR_W-1:0] next_pc
);

   localparam logic [ADDR_W-1:0] UM = 1;

   // PC source mux; increment wraps naturally at ADDR_W bits
   always_comb begin
      next_pc = pc;
      unique case (fonte_cp)
         FCP_SEQ: next_pc = pc + UM;
         FCP_ULA: next_pc = ula_res;
         FCP_JMP: next_pc = {pc[ADDR_W-1:12], imm12};
         default: next_pc = pc;
      endcase
   end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: owns PC and IR, fetches over req/ready
// and exposes the decoded IR fields to the control unit.
module busca_instrucao
   import busca_instrucao_pkg::*;
#(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              EscCP,
   input  logic              EscCondCP,
   input  logic [1:0]        FonteCP,
   input  logic              zero,
   input  logic [ADDR_W-1:0] ula_res,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_data,
   output logic [ADDR_W-1:0] pc,
   output logic              instr_valid,
   output logic [3:0]        opcode,
   output logic [3:0]        rd,
   output logic [3:0]        rs,
   output logic [3:0]        rt,
   output logic [7:0]        imm8,
   output logic [11:0]       imm12
);

   estado_t           estado;
   logic [DATA_W-1:0] ir;
   logic [ADDR_W-1:0] next_pc;
   logic              pc_write;

   assign pc_write = escreve_pc(EscCP, EscCondCP, zero);

   assign mem_addr = pc;
   assign opcode   = ir[15:12];
   assign rd       = ir[11:8];
   assign rs       = ir[7:4];
   assign rt       = ir[3:0];
   assign imm8     = ir[7:0];
   assign imm12    = ir[11:0];

   busca_instrucao_calc_prox_pc #(
      .ADDR_W (ADDR_W)
   ) u_calc_prox_pc (
      .pc       (pc),
      .ula_res  (ula_res),
      .imm12    (imm12),
      .fonte_cp (FonteCP),
      .next_pc  (next_pc)
   );

   // Fetch FSM; mem_req is registered and tracks the BUSCA state
   always_ff @(posedge clk) begin
      if (rst) begin
         estado      <= REINICIO;
         pc          <= RESET_PC;
         ir          <= '0;
         instr_valid <= 1'b0;
         mem_req     <= 1'b0;
      end else begin
         unique case (estado)
            REINICIO: begin
               estado  <= BUSCA;
               mem_req <= 1'b1;
            end
            BUSCA: begin
               if (mem_ready) begin
                  ir          <= mem_data;
                  instr_valid <= 1'b1;
                  mem_req     <= 1'b0;
                  estado      <= PRONTO;
               end
            end
            PRONTO: begin
               if (pc_write) begin
                  pc          <= next_pc;
                  instr_valid <= 1'b0;
                  mem_req     <= 1'b1;
                  estado      <= BUSCA;
               end
            end
            default: begin
               estado      <= REINICIO;
               instr_valid <= 1'b0;
               mem_req     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_busca_instrucao.sv
// Fetch stage bench: directed scenarios plus random control traffic,
// with a scoreboard of expected fetches checked by a monitor.
module tb_busca_instrucao;

   logic        clk = 1'b0;
   logic        rst;
   logic        EscCP, EscCondCP, zero;
   logic [1:0]  FonteCP;
   logic [15:0] ula_res;
   logic        mem_req, mem_ready;
   logic [15:0] mem_addr, mem_data, pc;
   logic        instr_valid;
   logic [3:0]  opcode, rd, rs, rt;
   logic [7:0]  imm8;
   logic [11:0] imm12;

   logic        force_hi, force_lo, rnd_ready;
   logic [15:0] imem [0:65535];
   logic [15:0] model_pc;
   logic        prev_iv = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] word;
   } fetch_t;
   fetch_t exp_q[$];

   always #5 clk = ~clk;

   assign mem_ready = force_hi | (~force_lo & rnd_ready);
   assign mem_data  = imem[mem_addr];

   busca_instrucao dut (
      .clk         (clk),
      .rst         (rst),
      .EscCP       (EscCP),
      .EscCondCP   (EscCondCP),
      .FonteCP     (FonteCP),
      .zero        (zero),
      .ula_res     (ula_res),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_data    (mem_data),
      .pc          (pc),
      .instr_valid (instr_valid),
      .opcode      (opcode),
      .rd          (rd),
      .rs          (rs),
      .rt          (rt),
      .imm8        (imm8),
      .imm12       (imm12)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic push_fetch(input logic [15:0] a);
      fetch_t f;
      f.addr = a;
      f.word = imem[a];
      exp_q.push_back(f);
   endtask

   // Wait for a ready instruction, apply one control command,
   // update the reference PC and check the result one cycle later.
   task automatic cmd(input logic esc, input logic cond,
                      input logic [1:0] fcp, input logic z,
                      input logic [15:0] ula);
      int          n;
      logic        w;
      logic [15:0] nx;
      logic [15:0] word;
      n = 0;
      @(negedge clk);
      while (!instr_valid && n < 100) begin
         EscCP     = 1'($urandom);
         EscCondCP = 1'($urandom);
         FonteCP   = 2'($urandom);
         zero      = 1'($urandom);
         ula_res   = 16'($urandom);
         n++;
         @(negedge clk);
      end
      if (!instr_valid) begin
         chk("wait_ready_timeout", 0, 1);
         EscCP = 1'b0;
         return;
      end
      EscCP     = esc;
      EscCondCP = cond;
      FonteCP   = fcp;
      zero      = z;
      ula_res   = ula;
      w = esc & (~cond | z);
      if (w) begin
         word = imem[model_pc];
         case (fcp)
            2'b00:   nx = model_pc + 16'd1;
            2'b01:   nx = ula;
            2'b10:   nx = {model_pc[15:12], word[11:0]};
            default: nx = model_pc;
         endcase
         model_pc = nx;
         push_fetch(nx);
      end
      @(negedge clk);
      EscCP     = 1'b0;
      EscCondCP = 1'b0;
      chk("pc_after_cmd", pc, model_pc);
      chk("valid_after_cmd", instr_valid, !w);
   endtask

   always @(negedge clk) rnd_ready = 1'($urandom);

   // Monitor: every newly valid instruction must match the next
   // expected fetch (address and decoded fields)
   always @(negedge clk) begin
      fetch_t e;
      if (instr_valid && !prev_iv) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_fetch", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("fetch_pc", pc, e.addr);
            chk("opcode", opcode, e.word[15:12]);
            chk("rd", rd, e.word[11:8]);
            chk("rs", rs, e.word[7:4]);
            chk("rt", rt, e.word[3:0]);
            chk("imm8", imm8, e.word[7:0]);
            chk("imm12", imm12, e.word[11:0]);
         end
      end
      prev_iv = instr_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 65536; i++) imem[i] = 16'($urandom);
      imem[16'h0000] = 16'h1234;
      imem[16'h0010] = 16'hC010;
      imem[16'h3007] = 16'hB123;
      rst = 1'b1;
      force_hi = 1'b1;
      force_lo = 1'b0;
      EscCP = 1'b0;
      EscCondCP = 1'b0;
      FonteCP = 2'b00;
      zero = 1'b0;
      ula_res = 16'h0000;
      model_pc = 16'h0000;
      repeat (3) @(negedge clk);
      chk("rst_pc", pc, 16'h0000);
      chk("rst_valid", instr_valid, 0);
      chk("rst_req", mem_req, 0);
      rst = 1'b0;
      push_fetch(16'h0000);
      @(negedge clk);
      chk("req_after_reinicio", mem_req, 1);
      chk("addr_first", mem_addr, 16'h0000);
      @(negedge clk);
      chk("first_valid", instr_valid, 1);
      chk("first_opcode", opcode, 4'h1);
      chk("first_rd", rd, 4'h2);
      chk("first_rs", rs, 4'h3);
      chk("first_rt", rt, 4'h4);
      chk("req_low_pronto", mem_req, 0);

      cmd(1, 0, 2'b01, 0, 16'h0005);
      cmd(1, 0, 2'b00, 0, 16'h0000);
      chk("seq_pc", pc, 16'h0006);
      chk("seq_req", mem_req, 1);
      chk("seq_addr", mem_addr, 16'h0006);

      cmd(1, 0, 2'b01, 0, 16'hFFFF);
      cmd(1, 0, 2'b00, 0, 16'h0000);
      chk("wrap_pc", pc, 16'h0000);

      cmd(1, 0, 2'b01, 0, 16'h0010);
      cmd(1, 1, 2'b01, 0, 16'h0040);
      chk("br_not_taken_pc", pc, 16'h0010);
      chk("br_not_taken_op", opcode, 4'hC);
      cmd(1, 1, 2'b01, 1, 16'h0040);
      chk("br_taken_pc", pc, 16'h0040);

      cmd(1, 0, 2'b01, 0, 16'h3007);
      cmd(1, 0, 2'b10, 0, 16'h0000);
      chk("jump_pc", pc, 16'h3123);
      cmd(1, 0, 2'b11, 0, 16'h0000);
      chk("reserved_pc", pc, 16'h3123);
      chk("reserved_req", mem_req, 1);

      cmd(1, 0, 2'b00, 0, 16'h0000);
      force_hi = 1'b0;
      force_lo = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_req", mem_req, 1);
         chk("stall_addr", mem_addr, 16'h3124);
         chk("stall_pc", pc, 16'h3124);
         EscCP   = 1'b1;
         FonteCP = 2'b01;
         ula_res = 16'($urandom);
      end
      EscCP = 1'b0;
      force_lo = 1'b0;
      force_hi = 1'b1;
      @(negedge clk);
      chk("stall_loaded", instr_valid, 1);

      cmd(1, 0, 2'b00, 0, 16'h0000);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      model_pc = 16'h0000;
      chk("midrst_valid", instr_valid, 0);
      chk("midrst_pc", pc, 16'h0000);
      chk("midrst_req", mem_req, 0);
      chk("midrst_ir", {opcode, rd, rs, rt}, 16'h0000);
      push_fetch(16'h0000);
      @(negedge clk);
      chk("reinicio_discard", instr_valid, 0);
      chk("refetch_addr", mem_addr, 16'h0000);
      @(negedge clk);
      chk("refetch_op", opcode, 4'h1);

      force_hi = 1'b0;
      for (int i = 0; i < 400; i++) begin
         cmd($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom),
             1'($urandom), 16'($urandom));
      end

      force_hi = 1'b1;
      repeat (4) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
- Instruction-fetch stage directly upstream of the multicycle control unit.
- Owns the PC and the instruction register (IR) and fetches 16-bit instructions from instruction memory with a req/ready handshake.
- Decodes opcode and operand fields for the control unit and datapath.
- Updates the PC from the control unit's EscCP/EscCondCP/FonteCP signals.

Parameters:
- DATA_W, 16, instruction width; field layout below assumes 16.
- ADDR_W, 16, PC / instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- EscCP  input  1  PC write request from the control unit.
- EscCondCP  input  1  makes the PC write conditional on zero.
- FonteCP  input  2  PC source select.
- zero  input  1  ALU zero flag.
- ula_res  input  ADDR_W  ALU result; branch target.
- mem_req  output  1  instruction-memory read request.
- mem_addr  output  ADDR_W  read address; equals pc.
- mem_ready  input  1  memory has data valid this cycle.
- mem_data  input  DATA_W  instruction word.
- pc  output  ADDR_W  current PC.
- instr_valid  output  1  IR holds a fetched instruction.
- opcode  output  4  IR[15:12].
- rd  output  4  IR[11:8].
- rs  output  4  IR[7:4].
- rt  output  4  IR[3:0].
- imm8  output  8  IR[7:0], zero-extended by the consumer.
- imm12  output  12  IR[11:0], jump target field.

Behaviour:
- States: REINICIO, BUSCA, PRONTO.
- Reset: state=REINICIO, pc=RESET_PC, IR=0, instr_valid=0. mem_req=0 during reset and in REINICIO.
- REINICIO -> BUSCA unconditionally on the next clock.
- BUSCA:
  - mem_req=1, mem_addr=pc, held stable until mem_ready=1 (valid/ready; no request withdrawal).
  - On mem_ready=1: IR<=mem_data, instr_valid<=1, go to PRONTO. The same-cycle ready is accepted, giving a minimum fetch latency of 1 cycle.
- PRONTO:
  - mem_req=0; IR and instr_valid held.
  - pc_write = EscCP & (~EscCondCP | zero).
  - If pc_write: pc<=next_pc, instr_valid<=0, go to BUSCA.
  - Otherwise stay in PRONTO indefinitely; the control unit may take any number of cycles.
- next_pc by FonteCP:
  - 00: pc+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - 01: ula_res.
  - 10: {pc[ADDR_W-1:12], imm12}.
  - 11: reserved; pc unchanged, but the transition to BUSCA still occurs (re-fetch the same address).
- Conditional not taken (EscCondCP=1, zero=0, EscCP=1): no PC write; stay in PRONTO.
- EscCP/EscCondCP/FonteCP are ignored in REINICIO and BUSCA. The PC never changes while a request is outstanding.
- mem_ready is ignored when mem_req=0.
- Reset mid-fetch: the outstanding request is abandoned. A mem_ready arriving in the reset cycle or in REINICIO is discarded.
- Field outputs are combinational slices of the IR. They are only meaningful while instr_valid=1, and hold the last IR otherwise.

Decomposition:
- Shared package or include: state encodings (REINICIO, BUSCA, PRONTO) and FonteCP codes (FCP_SEQ=00, FCP_ULA=01, FCP_JMP=10). The control unit uses the same FonteCP codes.
- One natural sub-module, calc_prox_pc: combinational next-PC mux (pc, ula_res, imm12, FonteCP -> next_pc). Everything else stays flat.

Test Plan:
- Reset then mem_ready tied 1, mem_data=0x1234 -> mem_req rises the cycle after REINICIO with mem_addr=0. One cycle later instr_valid=1, opcode=1, rd=2, rs=3, rt=4.
- In PRONTO pulse EscCP=1, FonteCP=00 with pc=0x0005 -> pc=0x0006, instr_valid=0, new request at 0x0006. pc=0xFFFF with FonteCP=00 -> wraps to 0x0000.
- Branch: IR=0xC010, pc=0x0010, EscCP=1, EscCondCP=1, FonteCP=01, ula_res=0x0040: zero=1 -> pc=0x0040; zero=0 -> pc stays 0x0010, state stays PRONTO.
- Jump: pc=0x3007, IR=0xB123, EscCP=1, FonteCP=10 -> pc=0x3123.
- Memory stalls: mem_ready=0 for 5 cycles -> mem_req and mem_addr stable, EscCP pulses ignored, pc unchanged. mem_ready=1 on cycle 6 -> IR loaded.
- Assert rst while in BUSCA with mem_ready=1 in the same cycle -> IR=0, instr_valid=0, pc=RESET_PC. A fresh fetch starts at RESET_PC.
